// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one sequential divider among N requesters, with watchdog abort.
// Optional: define DIVZERO_GUARD_EN to answer divide-by-zero requests locally without using the divider.
module div_arbiter #(
  parameter int WIDTH   = 16,
  parameter int N       = 3,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] req_dividend,
  input  logic [N*WIDTH-1:0] req_divisor,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       done,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic               div_start,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic               div_busy,
  input  logic               div_ready,
  input  logic [WIDTH-1:0]   div_quotient
);
  localparam int PW = $clog2(N);
  localparam logic [7:0] TO = 8'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_READY, DONE} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] ptr, gidx, pick;
  logic [7:0] wd;
  logic any, grant, waiting, fin_ok, fin_to, zero_div;
  logic [WIDTH-1:0] dd_arr [N];
  logic [WIDTH-1:0] dv_arr [N];
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign dd_arr[i] = req_dividend[i*WIDTH +: WIDTH];
    assign dv_arr[i] = req_divisor[i*WIDTH +: WIDTH];
  end
  // first requester at or after ptr; falls back to the lowest index when the search wraps
  always_comb begin
    pick = '0;
    any = 1'b0;
    for (int j = N - 1; j >= 0; j--)
      if (req[PW'(j)]) begin
        pick = PW'(j);
        any = 1'b1;
      end
    for (int j = N - 1; j >= 0; j--)
      if (req[PW'(j)] && PW'(j) >= ptr) pick = PW'(j);
  end
  assign grant   = state == IDLE && any && !div_busy;
  assign waiting = state == WAIT_BUSY || state == WAIT_READY;
  assign fin_ok  = waiting && div_ready;
  assign fin_to  = waiting && !div_ready && wd == TO;
`ifdef DIVZERO_GUARD_EN
  assign zero_div = dv_arr[pick] == '0;
`else
  assign zero_div = 1'b0;
`endif
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next-state: ready wins over busy, timeout wins over a late busy
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = grant ? (zero_div ? DONE : ISSUE) : IDLE;
      ISSUE:      state_nxt = WAIT_BUSY;
      WAIT_BUSY:  state_nxt = fin_ok || fin_to ? DONE : div_busy ? WAIT_READY : WAIT_BUSY;
      WAIT_READY: state_nxt = fin_ok || fin_to ? DONE : WAIT_READY;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end
  // operand latch, watchdog, result capture and pointer advance
  always_ff @(posedge clk)
    if (!rst_n) begin
      ptr <= '0;
      gidx <= '0;
      wd <= '0;
      result <= '0;
      err <= 1'b0;
      div_dividend <= '0;
      div_divisor <= '0;
    end else begin
      if (grant) begin
        gidx <= pick;
        div_dividend <= dd_arr[pick];
        div_divisor <= dv_arr[pick];
      end
      if ((grant && zero_div) || fin_to) begin
        result <= '1;
        err <= 1'b1;
      end
      if (fin_ok) begin
        result <= div_quotient;
        err <= 1'b0;
      end
      wd <= waiting ? wd + 8'd1 : 8'd0;
      if (state == DONE) ptr <= gidx == PW'(N - 1) ? '0 : gidx + 1'b1;
    end
  // outputs decoded from registered state: grant while busy, done only in DONE, start while waiting for busy
  always_comb begin
    gnt = state == IDLE ? '0 : {{(N-1){1'b0}}, 1'b1} << gidx;
    done = state == DONE ? gnt : '0;
    div_start = state == WAIT_BUSY;
  end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: scoreboard bench for div_arbiter with a behavioural divider and round-robin model.
module tb_div_arbiter;
  localparam int W = 16;
  localparam int N = 3;
  localparam int TO = 255;
`ifdef DIVZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  typedef struct {int idx; logic [W-1:0] res; logic err;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] rdd = '0, rdv = '0;
  logic [N-1:0] gnt, done;
  logic [W-1:0] result, div_dividend, div_divisor;
  logic err, div_start;
  logic m_busy = 1'b0, m_ready = 1'b0, ext_busy = 1'b0;
  logic [W-1:0] m_q = '0;
  exp_t sb[$];
  int g_order[$];
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0, mptr = 0;
  int lat = 18, m_cnt = 0, e, f, g, base, n;
  bit stuck = 1'b0, skip_busy = 1'b0, m_act = 1'b0, ds_seen = 1'b0;
  bit done_flag [N];
  logic [N-1:0] req_e = '0, prev_gnt = '0;
  logic prev_ds = 1'b0;
  logic [W-1:0] last_res = '0, m_res = '0;
  int exp_order [4] = '{0, 1, 2, 0};

  always #5 clk = ~clk;

  div_arbiter #(.WIDTH(W), .N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dividend(rdd), .req_divisor(rdv),
    .gnt(gnt), .done(done), .result(result), .err(err), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(m_busy | ext_busy), .div_ready(m_ready), .div_quotient(m_q)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic exp_t expect_of(input int i, input logic [W-1:0] dd, input logic [W-1:0] dv);
    exp_t x;
    x.idx = i;
    x.res = dv == 0 ? {W{1'b1}} : dd / dv;
    x.err = GUARD && dv == 0;
    return x;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] dd, input logic [W-1:0] dv);
    req[i] = 1'b1;
    rdd[i*W +: W] = dd;
    rdv[i*W +: W] = dv;
    sb.push_back(expect_of(i, dd, dv));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      step();
      k++;
    end
    check(name, done_cnt >= target, 1);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    step();
    step();
    check(name, {gnt, done, result, err, div_start, div_dividend, div_divisor}, 0);
    rst_n = 1'b1;
  endtask

  // divider: busy after start, ready with the quotient lat+1 cycles later; all-ones on /0
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_busy = 1'b0; m_ready = 1'b0; m_act = 1'b0;
    end else if (m_ready) begin
      m_ready = 1'b0; m_act = 1'b0;
    end else if (m_act) begin
      if (m_cnt == 0) begin
        m_busy = 1'b0; m_ready = 1'b1; m_q = m_res;
      end else m_cnt--;
    end else if (div_start && !stuck) begin
      m_act = 1'b1;
      m_cnt = lat;
      m_busy = !skip_busy;
      m_res = div_divisor == 0 ? {W{1'b1}} : div_dividend / div_divisor;
    end
  end

  initial forever begin
    @(posedge clk);
    req_e = req;
  end

  // monitor: arbitration order, protocol invariants and scoreboard pops on done
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      sb.delete();
      mptr = 0; last_res = '0; prev_gnt = '0; prev_ds = 1'b0;
    end else begin
      check("gnt_onehot0", $onehot0(gnt), 1);
      if (div_start) check("start_has_gnt", gnt != 0, 1);
      if (div_start && !prev_ds) begin
        ds_seen = 1'b1;
        start_cyc = cyc;
      end
      if (gnt != 0 && prev_gnt == 0) begin
        e = -1;
        for (int k = 0; k < N; k++) if (e < 0 && req_e[(mptr + k) % N]) e = (mptr + k) % N;
        g_order.push_back(idx_of(gnt));
        check("winner", idx_of(gnt), e);
      end
      if (done != 0) begin
        g = idx_of(done);
        check("done_onehot", $onehot(done), 1);
        check("done_is_gnt", done, gnt);
        f = -1;
        foreach (sb[j]) if (f < 0 && sb[j].idx == g) f = j;
        if (f < 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: done for requester %0d, none outstanding", g);
        end else begin
          check("result", result, sb[f].res);
          check("err", err, sb[f].err);
          sb.delete(f);
        end
        done_cnt++;
        done_flag[g] = 1'b1;
        done_cyc = cyc;
        mptr = (g + 1) % N;
        last_res = result;
      end else check("result_hold", result, last_res);
      prev_gnt = gnt;
      prev_ds = div_start;
    end
  end

  initial begin
    repeat (3) step();
    check("rst_outputs", {gnt, done, result, err, div_start, div_dividend, div_divisor}, 0);
    rst_n = 1'b1;
    // single request: start two cycles after req, 7372/100 = 73
    set_req(0, 16'd7372, 16'd100);
    step();
    check("start_lat1", div_start, 0);
    step();
    check("start_lat2", div_start, 1);
    check("latch_dd", div_dividend, 16'd7372);
    check("latch_dv", div_divisor, 16'd100);
    wait_done(1, 100, "single_done");
    req = '0;
    // divider busy while idle blocks the grant
    step();
    ext_busy = 1'b1;
    base = done_cnt;
    set_req(2, 16'd900, 16'd30);
    repeat (5) step();
    check("busy_idle_hold", gnt, 0);
    ext_busy = 1'b0;
    wait_done(base + 1, 100, "busy_idle_done");
    req = '0;
    // contention after reset: order 0,1,2,0
    step();
    do_reset("rst_contention");
    g_order.delete();
    base = done_cnt;
    set_req(0, 16'd1000, 16'd10);
    set_req(1, 16'd2000, 16'd20);
    set_req(2, 16'd3000, 16'd7);
    sb.push_back(expect_of(0, 16'd1000, 16'd10));
    wait_done(base + 4, 400, "contention_done");
    req = '0;
    check("order_size", g_order.size() >= 4, 1);
    for (int k = 0; k < 4; k++) check("order", g_order[k], exp_order[k]);
    // stuck divider: timeout abort with all-ones
    step();
    stuck = 1'b1;
    base = done_cnt;
    req[0] = 1'b1;
    rdd[W-1:0] = 16'd50;
    rdv[W-1:0] = 16'd5;
    sb.push_back('{0, {W{1'b1}}, 1'b1});
    wait_done(base + 1, 400, "stuck_done");
    req = '0;
    check("stuck_latency", (done_cyc - start_cyc) >= TO && (done_cyc - start_cyc) <= TO + 4, 1);
    repeat (3) step();
    check("stuck_start_low", div_start, 0);
    stuck = 1'b0;
    // reset in WAIT_READY, then arbitration restarts from pointer 0
    step();
    lat = 18;
    set_req(0, 16'd5000, 16'd50);
    n = 0;
    while (!m_busy && n < 50) begin
      step();
      n++;
    end
    check("midop_busy", m_busy, 1);
    repeat (3) step();
    check("midop_wait_ready", {div_start, gnt}, 4'b0001);
    rst_n = 1'b0;
    req = '0;
    step();
    check("midop_rst", {gnt, done, result, err, div_start, div_dividend, div_divisor}, 0);
    rst_n = 1'b1;
    g_order.delete();
    base = done_cnt;
    set_req(0, 16'd600, 16'd6);
    set_req(2, 16'd700, 16'd7);
    wait_done(base + 2, 200, "after_rst_done");
    req = '0;
    check("after_rst_first", g_order[0], 0);
    check("after_rst_second", g_order[1], 2);
    // divide by zero
    step();
    ds_seen = 1'b0;
    base = done_cnt;
    set_req(0, 16'd500, 16'd0);
    wait_done(base + 1, 100, "divzero_done");
    req = '0;
    check("divzero_start", ds_seen, !GUARD);
    // withdrawal during WAIT_BUSY still completes and advances the pointer
    step();
    ds_seen = 1'b0;
    base = done_cnt;
    set_req(1, 16'd4444, 16'd44);
    n = 0;
    while (!ds_seen && n < 20) begin
      step();
      n++;
    end
    check("withdraw_started", ds_seen, 1);
    req[1] = 1'b0;
    wait_done(base + 1, 100, "withdraw_done");
    g_order.delete();
    step();
    base = done_cnt;
    set_req(0, 16'd800, 16'd8);
    set_req(1, 16'd900, 16'd9);
    wait_done(base + 2, 200, "withdraw_next_done");
    req = '0;
    check("withdraw_ptr_first", g_order[0], 0);
    check("withdraw_ptr_second", g_order[1], 1);
    // randomized traffic
    step();
    for (int i = 0; i < N; i++) done_flag[i] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      step();
      lat = $urandom_range(0, 20);
      skip_busy = $urandom_range(0, 3) == 0;
      for (int i = 0; i < N; i++) begin
        if (done_flag[i]) begin
          done_flag[i] = 1'b0;
          if ($urandom_range(0, 1) == 1)
            set_req(i, W'($urandom), $urandom_range(0, 15) == 0 ? 16'd0 : W'($urandom_range(1, 400)));
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0)
          set_req(i, W'($urandom), $urandom_range(0, 15) == 0 ? 16'd0 : W'($urandom_range(1, 400)));
      end
    end
    n = 0;
    while (req != 0 && n < 3000) begin
      step();
      for (int i = 0; i < N; i++)
        if (done_flag[i]) begin
          done_flag[i] = 1'b0;
          req[i] = 1'b0;
        end
      n++;
    end
    check("drain", req, 0);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
